// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the N:1 TDM link. Samples arrive one per cycle
// (when DV is high) on a shared bus, slot 0 marked by FS. A slot counter
// tracks position in the frame, alignment is checked on every accepted
// sample, and each sample is registered into its channel of Y.
//
// Parameters:
//   W        sample width in bits
//   N        channels per frame (2..16)
// Ports:
//   CLK      rising-edge clock
//   RST_N    asynchronous active-low reset
//   D        sample data, qualified by DV
//   DV       sample valid
//   FS       frame sync, qualified by DV, marks slot 0
//   CLR_ERR  synchronous clear of ERR (a coinciding new error wins)
//   Y        channel registers, channel c at Y[c*W +: W]
//   YV       per-channel one-cycle update strobe
//   FV       one-cycle pulse when a complete frame has been delivered
//   LOCKED   frame alignment acquired
//   ERR      sticky alignment-error flag
//
// Build option:
//   TDM_DEMUX_SHADOW_EN  samples collect in shadow registers and all of Y
//                        loads at once on the last slot of a frame.

module tdm_demux #(
   parameter int unsigned W = 8,
   parameter int unsigned N = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [W-1:0]     D,
   input  logic             DV,
   input  logic             FS,
   input  logic             CLR_ERR,
   output logic [N*W-1:0]   Y,
   output logic [N-1:0]     YV,
   output logic             FV,
   output logic             LOCKED,
   output logic             ERR
);

   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N - 1);

   localparam logic ST_UNLOCKED = 1'b0;
   localparam logic ST_LOCKED   = 1'b1;

   logic             state_q;
   logic             state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             wr_en;
   logic [CNT_W-1:0] wr_slot;
   logic             wr_last;
   logic             set_err;

   // Frame alignment tracking: decides whether the current sample is
   // written, into which slot, and what the counter/state become.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_en   = 1'b0;
      wr_slot = '0;
      set_err = 1'b0;
      if (DV) begin
         case (state_q)
            ST_UNLOCKED: begin
               if (FS) begin
                  wr_en   = 1'b1;
                  cnt_d   = CNT_W'(1);
                  state_d = ST_LOCKED;
               end
            end
            default: begin
               if (FS) begin
                  // Normal frame start or early sync; either way restart at
                  // slot 0. The partial frame is dropped simply because its
                  // last slot is never reached.
                  wr_en   = 1'b1;
                  cnt_d   = CNT_W'(1);
                  set_err = (cnt_q != '0);
               end else if (cnt_q != '0) begin
                  wr_en   = 1'b1;
                  wr_slot = cnt_q;
                  cnt_d   = (cnt_q == LAST_SLOT) ? '0 : cnt_q + CNT_W'(1);
               end else begin
                  // Missing sync: sample discarded, alignment lost.
                  set_err = 1'b1;
                  state_d = ST_UNLOCKED;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   // Slot 0 is never the last slot for N >= 2, so an FS write cannot
   // complete a frame.
   assign wr_last = wr_en && (wr_slot == LAST_SLOT);
   assign LOCKED  = (state_q == ST_LOCKED);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_UNLOCKED;
         cnt_q   <= '0;
         FV      <= 1'b0;
         ERR     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         FV      <= wr_last;
         if (set_err) begin
            ERR <= 1'b1;
         end else if (CLR_ERR) begin
            ERR <= 1'b0;
         end
      end
   end

`ifdef TDM_DEMUX_SHADOW_EN
   logic [N*W-1:0] shadow_q;

   // Y only changes on frame completion; the last sample bypasses the
   // shadow so the whole frame lands in the same output cycle.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         shadow_q <= '0;
         Y        <= '0;
         YV       <= '0;
      end else begin
         YV <= '0;
         if (wr_en) begin
            for (int unsigned c = 0; c < N; c++) begin
               if (wr_slot == CNT_W'(c)) begin
                  shadow_q[c*W +: W] <= D;
               end
            end
            if (wr_last) begin
               Y  <= {D, shadow_q[(N-1)*W-1:0]};
               YV <= '1;
            end
         end
      end
   end
`else
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Y  <= '0;
         YV <= '0;
      end else begin
         YV <= '0;
         for (int unsigned c = 0; c < N; c++) begin
            if (wr_en && (wr_slot == CNT_W'(c))) begin
               Y[c*W +: W] <= D;
               YV[c]       <= 1'b1;
            end
         end
      end
   end
`endif

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: receives samples time-multiplexed onto one data bus with a frame-sync marker and distributes them to N registered parallel channel outputs. It is the receive end of the team's N:1 mux-based TDM link; a transmitter drives slot 0 with FS high and slots 1..N-1 in order. It tracks slot position with a counter, checks frame alignment, and flags errors.

## Interface
- W, default 8: sample width in bits.
- N, default 4: channels per frame, 2..16.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- D  input  W  sample data, valid when DV=1.
- DV  input  1  sample valid; one sample per cycle max.
- FS  input  1  frame sync; qualified by DV, marks the slot-0 sample.
- CLR_ERR  input  1  synchronous clear of ERR.
- Y  output  N*W  channel registers; channel c at Y[c*W +: W].
- YV  output  N  per-channel one-cycle update strobe.
- FV  output  1  one-cycle pulse: complete frame delivered.
- LOCKED  output  1  frame alignment acquired.
- ERR  output  1  sticky alignment-error flag.

## Operation
- Reset values: Y=0, YV=0, FV=0, LOCKED=0, ERR=0, slot counter=0, state UNLOCKED.
- UNLOCKED: DV without FS is discarded. DV&FS writes D to slot 0 and moves to LOCKED with counter=1.
- LOCKED, DV=1, counter=c:
  - FS=0, c!=0: write slot c; counter=c+1, wrapping N-1 -> 0.
  - FS=1, c==0: normal frame start; write slot 0; counter=1.
  - FS=1, c!=0 (early sync): set ERR, write slot 0, counter=1, stay LOCKED; discard the partial frame (no FV).
  - FS=0, c==0 (missing sync): set ERR, discard sample, go UNLOCKED, counter=0.
- DV=0: no state change, and YV=0 and FV=0 next cycle.
- FV pulses when slot N-1 is written while LOCKED.
- ERR clears only via CLR_ERR or reset. If CLR_ERR coincides with a new error, set wins.
- Counter width is ceil(log2 N). Wrap happens only at N-1, also for non-power-of-2 N.

## Timing
- Latency of 1 cycle: a sample accepted at edge k appears on Y, with its YV bit, after edge k. YV and FV are high for exactly that cycle.
- LOCKED rises after the edge that accepts the first DV&FS. It falls after the edge that detects a missing sync.
- Back-to-back DV is supported at full rate. The last slot of frame f may be followed on the next cycle by slot 0 of frame f+1.
- RST_N assertion mid-frame immediately clears all outputs and state, asynchronously. Deassertion is expected to be synchronized externally, and the first accepted edge is the one after release.

## Configuration
- TDM_DEMUX_SHADOW_EN defined:
  - Samples go to internal shadow registers. Y is not written per slot.
  - On the slot N-1 write, all N channels of Y load together. In that output cycle YV is all ones and FV=1.
  - An early sync or missing sync leaves Y unchanged.
- Undefined: Y updates per slot as described above. FV pulses in the same output cycle as YV[N-1].

## Test plan
Default configuration unless noted; N=4, W=8.
- Reset then frame 0x10,0x11,0x12,0x13 (FS on first) -> LOCKED=1 after the first edge; Y channels 0..3 = 10,11,12,13; YV bit c pulses one cycle after its sample; FV pulses with YV[3]; ERR=0.
- Samples 0xAA,0xBB without FS while UNLOCKED -> Y stays 0, YV stays 0, LOCKED stays 0.
- Locked, send slots 0,1 then DV&FS 0x55 -> ERR=1; Y ch0=0x55; no FV; the next three samples fill ch1..3 and FV pulses.
- After a full frame, send DV with FS=0 -> ERR=1, LOCKED=0, Y unchanged. Then pulse CLR_ERR -> ERR=0 next cycle.
- Two frames with DV continuously high, then DV gaps of 1-3 cycles inside a frame -> correct slot mapping, one FV per frame. Assert RST_N low mid-frame -> all outputs 0 immediately.
- TDM_DEMUX_SHADOW_EN: frame 0x20..0x23 -> Y unchanged until the slot-3 output cycle, then all four channels update together with YV=4'b1111 and FV=1. An early sync mid-frame -> Y keeps the previous frame.
